// File: rtl/rr_arb_mux.sv
// Registered N:1 arbiter-mux: picks one valid/ready producer per cycle, either round-robin
// or fixed-priority, and holds the winning beat plus its channel index in a single output stage.
module rr_arb_mux #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 8,
    parameter int IDX_W  = $clog2(NUM_IN),
    parameter int MODE   = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_IN-1:0]       in_valid,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    output logic [NUM_IN-1:0]       in_ready,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic [IDX_W-1:0]        out_idx
);

    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] start_idx;
    logic [IDX_W-1:0] grant_idx;
    logic             grant_found;
    logic             can_load;
    logic             accept;

    // Circular scan from start_idx; the extra bit lets the sum wrap at NUM_IN, not 2^IDX_W.
    always_comb begin
        logic [IDX_W:0]   scan;
        logic [IDX_W-1:0] cand;
        scan        = '0;
        cand        = '0;
        start_idx   = (MODE == 0) ? ptr : '0;
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            scan = {1'b0, start_idx} + (IDX_W + 1)'(k);
            if (scan >= (IDX_W + 1)'(NUM_IN)) begin
                scan = scan - (IDX_W + 1)'(NUM_IN);
            end
            cand = scan[IDX_W-1:0];
            if (!grant_found && in_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    assign can_load = !out_valid || out_ready;
    assign accept   = can_load && grant_found && !rst;

    always_comb begin
        in_ready = '0;
        if (accept) begin
            in_ready[grant_idx] = 1'b1;
        end
    end

    // A new accept overwrites the register even while the old beat drains, so there is no bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_idx   <= '0;
            ptr       <= '0;
        end else begin
            if (accept) begin
                out_valid <= 1'b1;
                out_data  <= in_data[int'(grant_idx)*WIDTH +: WIDTH];
                out_idx   <= grant_idx;
                if (MODE == 0) begin
                    ptr <= (grant_idx == IDX_W'(NUM_IN - 1)) ? '0 : grant_idx + 1'b1;
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/rr_arb_mux.md
Name: rr_arb_mux

Overview:
- Parametrised, registered successor to the team's fixed 8:1 combinational mux.
- Selects one of NUM_IN valid/ready input channels by round-robin or fixed-priority arbitration.
- Registers the winner into a single output stage with a valid/ready handshake.
- Used in the pipeline wherever several producers share one consumer, e.g. writeback sources or memory request ports of the M/F/A units.

Parameters:
- WIDTH, 32, data width per channel in bits.
- NUM_IN, 8, number of input channels; legal range 2..16, need not be a power of 2.
- IDX_W, $clog2(NUM_IN), width of the channel index.
- MODE, 0, arbitration mode: 0 = round-robin, 1 = fixed priority (lowest index wins).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  NUM_IN  per-channel request; bit i belongs to channel i.
- in_data  in  NUM_IN*WIDTH  flattened data; channel i occupies bits [i*WIDTH +: WIDTH].
- in_ready  out  NUM_IN  per-channel accept; combinational; at most one bit set.
- out_valid  out  1  output register holds a beat.
- out_ready  in  1  consumer accepts the beat.
- out_data  out  WIDTH  registered data of the winning channel.
- out_idx  out  IDX_W  registered index of the channel that supplied out_data.

Behaviour:
- Reset (rst=1 at clk edge):
  - out_valid=0, out_data=0, out_idx=0, round-robin pointer ptr=0.
  - in_ready is forced to all-zero while rst=1.
  - A beat held in the output register at reset is discarded; no handshake completes in a reset cycle.
- can_load = !out_valid || out_ready. This is a pipeline register with full throughput of one beat per cycle.
- Grant (combinational):
  - MODE=0: first i with in_valid[i]=1, searching ptr, ptr+1, ..., NUM_IN-1, 0, ..., ptr-1.
  - MODE=1: lowest i with in_valid[i]=1.
  - No valid input means no grant.
- in_ready[g] = can_load && grant exists, for the granted channel g only. All other bits are 0.
- Accept: a transfer on channel g occurs when in_valid[g] && in_ready[g]. At the next edge:
  - out_data = channel g data, out_idx = g, out_valid = 1.
- Output handshake:
  - A beat leaves when out_valid && out_ready.
  - If no new accept happens in the same cycle, out_valid goes to 0 and out_data/out_idx hold their last values.
- Stall: while out_valid=1 and out_ready=0:
  - out_data, out_idx and out_valid hold.
  - All in_ready bits are 0 and ptr holds.
- Simultaneous drain and accept: the new beat replaces the old one in the same edge, out_valid stays 1, with no bubble.
- Pointer update (MODE=0 only):
  - On accept from g, ptr = g+1, wrapping to 0 when g = NUM_IN-1.
  - Unchanged when there is no accept. Non-power-of-2 NUM_IN wraps at NUM_IN-1, never at 2^IDX_W.
  - In MODE=1, ptr is unused and stays 0.
- Latency: 1 cycle from input accept to out_valid.
- Inputs are not required to hold in_valid/in_data stable while unaccepted; the block samples only on accept.
- Index values >= NUM_IN never appear on out_idx.
- Ordering: beats from a single channel leave in acceptance order. Each beat is delivered exactly once: none dropped, none duplicated, except beats discarded by reset.

Test Plan:
- Reset, then in_valid=0 -> out_valid=0, out_data=0, out_idx=0, in_ready=0 for 3 cycles.
- MODE=0, NUM_IN=8, all 8 channels valid with data 0x100+i, out_ready=1 for 16 cycles:
  - Expect out_idx 0,1,...,7,0,...,7 on consecutive cycles after 1-cycle latency.
  - Expect out_data = 0x100+out_idx.
- Stall: channel 3 valid (0xDEAD), accepted, then out_ready=0 for 4 cycles with channel 5 valid:
  - out_data holds 0xDEAD, out_idx=3, in_ready=0.
  - When out_ready returns to 1, channel 5 is accepted that same cycle and appears on the next edge with no bubble.
- Wrap with NUM_IN=5, MODE=0: after an accept from channel 4, with channels 0 and 2 valid -> channel 0 is granted next, then 2.
- MODE=1, channels 1 and 6 valid continuously -> channel 1 wins every cycle; in_ready[6] stays 0 throughout.
- Reset mid-operation: assert rst for 1 cycle while out_valid=1 and out_ready=0:
  - Next cycle out_valid=0 and ptr=0.
  - With channels 2 and 7 valid afterwards, the first grant goes to 2.
